ddc_fir_sched: RTL and testbench

Time-shares one FIR decimation core between the I and Q branches of the DDC, in place of one FIR instance per branch. Sits between the CIC stage output register and the DDC output. The shared FIR core is configured for 2 interleaved channels: sample 0 is I, sample 1 is Q.
- Sequences each CIC I/Q pair into the FIR as two consecutive beats.
- Collects the two FIR results and rounds them.
- Emits one aligned DDC I/Q output pulse.
- Provides a one-deep hold buffer, an overflow counter and a response timeout.

---
 rtl/ddc_fir_sched.sv | 143 ++++++++++++++
 tb/tb_ddc_fir_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_fir_sched.sv
// ddc_fir_sched: time-shares one 2-channel FIR decimator between the DDC I and Q branches.
// Feeds each CIC pair as an I/Q beat pair, rounds the two results and emits one aligned output.
module ddc_fir_sched #(
    parameter int DW      = 16,
    parameter int FW      = 42,
    parameter int RND_MSB = 34,
    parameter int RND_LSB = 19,
    parameter int TMO     = 4095
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cic_doe_i,
    input  logic [DW-1:0] cic_dati_i,
    input  logic [DW-1:0] cic_datq_i,
    output logic          fir_sink_valid_o,
    output logic [DW-1:0] fir_sink_data_o,
    input  logic          fir_src_valid_i,
    input  logic [FW-1:0] fir_src_data_i,
    output logic          ddc_doe_o,
    output logic [DW-1:0] ddc_dati_o,
    output logic [DW-1:0] ddc_datq_o,
    output logic          busy_o,
    output logic [7:0]    ovf_cnt_o,
    output logic          tmo_err_o,
    input  logic          clr_err_i
);
    typedef enum logic [1:0] {IDLE, SEND_Q, WAIT_I, WAIT_Q} state_t;
    localparam logic [11:0] TMO_C = 12'(TMO);
    state_t        state_q, state_d;
    logic          sink_v_q, sink_v_d, buf_v_q, buf_v_d, doe_q, doe_d, busy_q, busy_d, tmo_q, tmo_d;
    logic [DW-1:0] sink_dat_q, sink_dat_d, qlat_q, qlat_d, buf_i_q, buf_i_d, buf_q_q, buf_q_d;
    logic [DW-1:0] res_i_q, res_i_d, dati_q, dati_d, datq_q, datq_d, rnd;
    logic [11:0]   timer_q, timer_d;
    logic [7:0]    ovf_q, ovf_d;
    logic          drop, timeout, unused_bits;
    // Round half up on the kept slice; wraps modulo 2^DW by design.
    assign rnd = fir_src_data_i[RND_MSB:RND_LSB] + DW'(fir_src_data_i[RND_LSB-1]);
    assign unused_bits = ^{fir_src_data_i[FW-1:RND_MSB+1], fir_src_data_i[RND_LSB-2:0]};
    always_comb begin
        state_d    = state_q;
        sink_v_d   = 1'b0;
        sink_dat_d = sink_dat_q;
        qlat_d     = qlat_q;
        buf_v_d    = buf_v_q;
        buf_i_d    = buf_i_q;
        buf_q_d    = buf_q_q;
        timer_d    = timer_q;
        res_i_d    = res_i_q;
        doe_d      = 1'b0;
        dati_d     = dati_q;
        datq_d     = datq_q;
        drop       = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            IDLE: if (buf_v_q || cic_doe_i) begin
                state_d    = SEND_Q;
                sink_v_d   = 1'b1;
                sink_dat_d = buf_v_q ? buf_i_q : cic_dati_i;
                qlat_d     = buf_v_q ? buf_q_q : cic_datq_i;
                // A buffered pair goes first; a simultaneous new pair takes its slot.
                buf_v_d    = buf_v_q && cic_doe_i;
                buf_i_d    = cic_dati_i;
                buf_q_d    = cic_datq_i;
            end
            SEND_Q: begin
                state_d    = WAIT_I;
                sink_v_d   = 1'b1;
                sink_dat_d = qlat_q;
                timer_d    = '0;
            end
            default: begin
                timer_d = timer_q + 12'd1;
                if (timer_q == TMO_C) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else if (fir_src_valid_i && state_q == WAIT_I) begin
                    res_i_d = rnd;
                    state_d = WAIT_Q;
                end else if (fir_src_valid_i) begin
                    doe_d   = 1'b1;
                    dati_d  = res_i_q;
                    datq_d  = rnd;
                    state_d = IDLE;
                end
            end
        endcase
        if (state_q != IDLE && cic_doe_i) begin
            if (buf_v_q) begin
                drop = 1'b1;
            end else begin
                buf_v_d = 1'b1;
                buf_i_d = cic_dati_i;
                buf_q_d = cic_datq_i;
            end
        end
        ovf_d  = clr_err_i ? 8'd0 : (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
        tmo_d  = clr_err_i ? 1'b0 : tmo_q | timeout;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sink_v_q   <= 1'b0;
            sink_dat_q <= '0;
            qlat_q     <= '0;
            buf_v_q    <= 1'b0;
            buf_i_q    <= '0;
            buf_q_q    <= '0;
            timer_q    <= '0;
            res_i_q    <= '0;
            doe_q      <= 1'b0;
            dati_q     <= '0;
            datq_q     <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sink_v_q   <= sink_v_d;
            sink_dat_q <= sink_dat_d;
            qlat_q     <= qlat_d;
            buf_v_q    <= buf_v_d;
            buf_i_q    <= buf_i_d;
            buf_q_q    <= buf_q_d;
            timer_q    <= timer_d;
            res_i_q    <= res_i_d;
            doe_q      <= doe_d;
            dati_q     <= dati_d;
            datq_q     <= datq_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
        end
    end
    assign fir_sink_valid_o = sink_v_q;
    assign fir_sink_data_o  = sink_dat_q;
    assign ddc_doe_o        = doe_q;
    assign ddc_dati_o       = dati_q;
    assign ddc_datq_o       = datq_q;
    assign busy_o           = busy_q;
    assign ovf_cnt_o        = ovf_q;
    assign tmo_err_o        = tmo_q;
endmodule

// File: tb/tb_ddc_fir_sched.sv
// tb_ddc_fir_sched: directed bench for ddc_fir_sched with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_ddc_fir_sched;
    localparam int TMO = 4095;
    logic        clk = 1'b0, rst_n, cic_doe, fir_src_valid, clr_err;
    logic [15:0] cic_dati, cic_datq;
    logic [41:0] fir_src_data;
    logic        fir_sink_valid, ddc_doe, busy, tmo_err;
    logic [15:0] fir_sink_data, ddc_dati, ddc_datq;
    logic [7:0]  ovf_cnt;
    int          checks = 0, errors = 0;

    ddc_fir_sched dut (
        .clk(clk), .rst_n(rst_n),
        .cic_doe_i(cic_doe), .cic_dati_i(cic_dati), .cic_datq_i(cic_datq),
        .fir_sink_valid_o(fir_sink_valid), .fir_sink_data_o(fir_sink_data),
        .fir_src_valid_i(fir_src_valid), .fir_src_data_i(fir_src_data),
        .ddc_doe_o(ddc_doe), .ddc_dati_o(ddc_dati), .ddc_datq_o(ddc_datq),
        .busy_o(busy), .ovf_cnt_o(ovf_cnt), .tmo_err_o(tmo_err), .clr_err_i(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rnd(input logic [41:0] d);
        return 16'((d >> 19) + ((d >> 18) & 42'd1));
    endfunction

    // FIR result with the given kept slice and rounding bit; other bits are noise.
    function automatic logic [41:0] mk(input logic [15:0] h, input logic b);
        return (42'(h) << 19) | (42'(b) << 18) | (42'h3 << 40) | 42'h2A5AA;
    endfunction

    // Reference model: pairs accepted but not yet started wait in hold[].
    typedef struct packed { logic [15:0] i; logic [15:0] q; } pair_t;
    pair_t       hold[$];
    bit          m_act;
    int          m_sent, m_got, m_wait;
    logic [15:0] m_curq, m_ri;
    logic        e_sv, e_doe, e_tmo;
    logic [15:0] e_sd, e_di, e_dq;
    int          e_ovf;

    task automatic model_reset();
        hold.delete();
        m_act = 0; m_sent = 0; m_got = 0; m_wait = 0; m_curq = 0; m_ri = 0;
        e_sv = 0; e_doe = 0; e_tmo = 0; e_sd = 0; e_di = 0; e_dq = 0; e_ovf = 0;
    endtask

    task automatic model_step();
        bit    was = m_act, drop = 0, hit = 0;
        pair_t p;
        e_sv = 0;
        e_doe = 0;
        if (cic_doe) begin
            if (was && hold.size() >= 1) drop = 1;
            else hold.push_back({cic_dati, cic_datq});
        end
        if (!was) begin
            if (hold.size() > 0) begin
                p = hold.pop_front();
                e_sv = 1; e_sd = p.i; m_curq = p.q;
                m_act = 1; m_sent = 1; m_got = 0;
            end
        end else if (m_sent == 1) begin
            e_sv = 1; e_sd = m_curq; m_sent = 2; m_wait = 0;
        end else begin
            if (m_wait == TMO) begin
                hit = 1; m_act = 0;
            end else if (fir_src_valid) begin
                if (m_got == 0) begin
                    m_ri = rnd(fir_src_data); m_got = 1;
                end else begin
                    e_doe = 1; e_di = m_ri; e_dq = rnd(fir_src_data); m_act = 0;
                end
            end
            m_wait++;
        end
        e_ovf = clr_err ? 0 : (drop && e_ovf < 255) ? e_ovf + 1 : e_ovf;
        e_tmo = clr_err ? 1'b0 : (e_tmo | hit);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            #1;
            chk("m_sink_valid", 32'(fir_sink_valid), 32'(e_sv));
            if (e_sv) chk("m_sink_data", 32'(fir_sink_data), 32'(e_sd));
            chk("m_ddc_doe", 32'(ddc_doe), 32'(e_doe));
            chk("m_ddc_dati", 32'(ddc_dati), 32'(e_di));
            chk("m_ddc_datq", 32'(ddc_datq), 32'(e_dq));
            chk("m_busy", 32'(busy), 32'(m_act));
            chk("m_ovf_cnt", 32'(ovf_cnt), 32'(e_ovf));
            chk("m_tmo_err", 32'(tmo_err), 32'(e_tmo));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pair(input logic [15:0] i, input logic [15:0] q);
        cic_doe = 1; cic_dati = i; cic_datq = q;
        tick(1);
        cic_doe = 0;
    endtask

    task automatic fir_res(input logic [41:0] d);
        fir_src_valid = 1; fir_src_data = d;
        tick(1);
        fir_src_valid = 0;
    endtask

    initial begin
        rst_n = 0; cic_doe = 0; cic_dati = 0; cic_datq = 0;
        fir_src_valid = 0; fir_src_data = 0; clr_err = 0;
        tick(3);
        rst_n = 1;
        tick(1);
        chk("rst_sink_valid", 32'(fir_sink_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ddc_doe", 32'(ddc_doe), 0);
        chk("rst_ovf", 32'(ovf_cnt), 0);
        chk("rst_tmo", 32'(tmo_err), 0);
        // single pair and rounding
        send_pair(16'h1234, 16'hABCD);
        chk("beat_i_valid", 32'(fir_sink_valid), 1);
        chk("beat_i_data", 32'(fir_sink_data), 32'h1234);
        chk("busy_t1", 32'(busy), 1);
        tick(1);
        chk("beat_q_valid", 32'(fir_sink_valid), 1);
        chk("beat_q_data", 32'(fir_sink_data), 32'hABCD);
        tick(1);
        chk("beats_end", 32'(fir_sink_valid), 0);
        tick(2);
        fir_res(mk(16'h0100, 1'b1));
        tick(2);
        fir_res(mk(16'h7FFF, 1'b1));
        chk("rnd_doe", 32'(ddc_doe), 1);
        chk("rnd_dati", 32'(ddc_dati), 32'h0101);
        chk("rnd_datq_wrap", 32'(ddc_datq), 32'h8000);
        tick(1);
        chk("rnd_doe_pulse", 32'(ddc_doe), 0);
        chk("rnd_dati_hold", 32'(ddc_dati), 32'h0101);
        chk("idle_busy", 32'(busy), 0);
        // buffer and overflow
        send_pair(16'hA001, 16'hA002);
        tick(4);
        send_pair(16'hB001, 16'hB002);
        tick(2);
        send_pair(16'hC001, 16'hC002);
        chk("ovf_one", 32'(ovf_cnt), 1);
        tick(11);
        fir_res(mk(16'h1111, 1'b0));
        fir_res(mk(16'h2222, 1'b1));
        chk("a_doe", 32'(ddc_doe), 1);
        chk("a_dati", 32'(ddc_dati), 32'h1111);
        chk("a_datq", 32'(ddc_datq), 32'h2223);
        tick(1);
        chk("b2b_beat_i", 32'(fir_sink_data), 32'hB001);
        chk("b2b_valid", 32'(fir_sink_valid), 1);
        tick(1);
        chk("b2b_beat_q", 32'(fir_sink_data), 32'hB002);
        tick(5);
        fir_res(mk(16'h3333, 1'b0));
        fir_res(mk(16'hFFFF, 1'b1));
        chk("b_dati", 32'(ddc_dati), 32'h3333);
        chk("b_datq_wrap", 32'(ddc_datq), 32'h0000);
        tick(1);
        chk("b_idle", 32'(busy), 0);
        // clear wins over a simultaneous drop
        send_pair(16'hD001, 16'hD002);
        tick(1);
        send_pair(16'hE001, 16'hE002);
        clr_err = 1;
        send_pair(16'hF001, 16'hF002);
        clr_err = 0;
        chk("clr_over_drop", 32'(ovf_cnt), 0);
        tick(2);
        fir_res(mk(16'h0A0A, 1'b1));
        fir_res(mk(16'h0B0B, 1'b0));
        chk("d_dati", 32'(ddc_dati), 32'h0A0B);
        chk("d_datq", 32'(ddc_datq), 32'h0B0B);
        tick(2);
        chk("e_beat_q", 32'(fir_sink_data), 32'hE002);
        tick(2);
        fir_res(mk(16'h8000, 1'b1));
        fir_res(mk(16'h7FFE, 1'b1));
        chk("e_dati", 32'(ddc_dati), 32'h8001);
        chk("e_datq", 32'(ddc_datq), 32'h7FFF);
        tick(2);
        // timeout
        send_pair(16'h6001, 16'h6002);
        tick(TMO + 1);
        chk("tmo_not_yet", 32'(tmo_err), 0);
        chk("tmo_busy_before", 32'(busy), 1);
        tick(1);
        chk("tmo_set", 32'(tmo_err), 1);
        chk("tmo_busy", 32'(busy), 0);
        fir_res(mk(16'h5555, 1'b0));
        chk("late_src_doe", 32'(ddc_doe), 0);
        tick(2);
        chk("late_src_dati", 32'(ddc_dati), 32'h8001);
        chk("late_src_busy", 32'(busy), 0);
        clr_err = 1;
        tick(1);
        clr_err = 0;
        chk("tmo_clear", 32'(tmo_err), 0);
        // async reset during WAIT_Q
        send_pair(16'h7001, 16'h7002);
        tick(3);
        fir_res(mk(16'h4444, 1'b0));
        send_pair(16'h7101, 16'h7102);
        send_pair(16'h7201, 16'h7202);
        chk("pre_rst_ovf", 32'(ovf_cnt), 1);
        #2 rst_n = 0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ovf", 32'(ovf_cnt), 0);
        chk("arst_dati", 32'(ddc_dati), 0);
        chk("arst_datq", 32'(ddc_datq), 0);
        chk("arst_sink", 32'({fir_sink_valid, fir_sink_data}), 0);
        chk("arst_doe_tmo", 32'({ddc_doe, tmo_err}), 0);
        tick(2);
        rst_n = 1;
        tick(2);
        chk("post_rst_idle", 32'(busy), 0);
        send_pair(16'h0F0F, 16'hF0F0);
        chk("post_beat_i", 32'(fir_sink_data), 32'h0F0F);
        tick(1);
        chk("post_beat_q", 32'(fir_sink_data), 32'hF0F0);
        tick(2);
        fir_res(mk(16'h0001, 1'b1));
        fir_res(mk(16'hFFFE, 1'b1));
        chk("post_doe", 32'(ddc_doe), 1);
        chk("post_dati", 32'(ddc_dati), 32'h0002);
        chk("post_datq", 32'(ddc_datq), 32'hFFFF);
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
